// File: rtl/cic_comp_down_mac.sv
// Decimate-by-2 CIC compensation FIR. Samples are written into a history
// buffer at the input rate; every second sample starts a full NTAPS-tap
// convolution. The convolution uses one multiplier, time-multiplexed at the
// system clock, followed by rounding and saturation to DW bits.
module cic_comp_down_mac #(
   parameter int                  DW              = 16,
   parameter int                  CW              = 19,
   parameter int                  NTAPS           = 120,
   parameter int                  DEPTH           = 128,
   parameter int                  SHIFT           = 18,
   parameter string               COEFF_INIT_FILE = "coeffs_dec.mem",
   parameter logic [CW*NTAPS-1:0] COEFFS          = '0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clk_enable,
   input  logic [DW-1:0] filter_in,
   output logic [DW-1:0] filter_out,
   output logic          ce_out,
   output logic          busy,
   output logic          overrun
);

   localparam int PW = DW + CW;
   localparam int AW = DW + CW + $clog2(NTAPS);
   localparam int AD = $clog2(DEPTH);
   localparam int TW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

   localparam logic [TW-1:0]      LAST_TAP = TW'(NTAPS - 1);
   localparam logic signed [AW:0] RND      = (SHIFT > 0) ?
                                             ((AW+1)'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
   localparam logic signed [AW:0] OMAX     = {{(AW+2-DW){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW:0] OMIN     = {{(AW+2-DW){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_OUT
   } state_t;

   state_t                state, state_nxt;

   logic signed [DW-1:0]  mem [DEPTH];
   logic signed [CW-1:0]  coef_rom [NTAPS];

   logic                  dphase;
   logic [AD-1:0]         w_ptr;
   logic [AD-1:0]         r_ptr;
   logic [TW-1:0]         tap_idx;
   logic [1:0]            drain_cnt;

   logic signed [DW-1:0]  x_q;
   logic signed [CW-1:0]  h_q;
   logic                  v1_q;
   logic signed [PW-1:0]  prod_q;
   logic                  v2_q;
   logic signed [AW-1:0]  acc;

   logic signed [AW:0]    rnd_sum;
   logic signed [AW:0]    rnd_t;
   logic [DW-1:0]         sat_val;

   logic                  trigger;
   logic                  start;

   // Coefficient ROM image taken from the parameter vector
   initial begin
      for (int unsigned k = 0; k < NTAPS; k++) coef_rom[k] = COEFFS[k*CW +: CW];
   end

   assign trigger = clk_enable & dphase;
   assign start   = trigger & (state == S_IDLE);

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic and status outputs
   always_comb begin
      state_nxt = state;
      busy      = (state != S_IDLE);
      ce_out    = (state == S_OUT);
      case (state)
         S_IDLE:  if (trigger)               state_nxt = S_RUN;
         S_RUN:   if (tap_idx == LAST_TAP)   state_nxt = S_DRAIN;
         S_DRAIN: if (drain_cnt == 2'd2)     state_nxt = S_OUT;
         S_OUT:                              state_nxt = S_IDLE;
         default:                            state_nxt = S_IDLE;
      endcase
   end

   // Sample intake: every strobe is stored, independent of the FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         w_ptr  <= '0;
         dphase <= 1'b0;
      end else if (clk_enable) begin
         mem[w_ptr] <= filter_in;
         w_ptr      <= w_ptr + AD'(1);
         dphase     <= ~dphase;
      end
   end

   // Tap sequencing: newest sample first, walking backwards through history
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tap_idx   <= '0;
         r_ptr     <= '0;
         drain_cnt <= '0;
      end else begin
         if (start) begin
            tap_idx <= '0;
            r_ptr   <= w_ptr;
         end else if (state == S_RUN) begin
            tap_idx <= tap_idx + TW'(1);
            r_ptr   <= r_ptr - AD'(1);
         end
         if (state == S_DRAIN) drain_cnt <= drain_cnt + 2'd1;
         else                  drain_cnt <= '0;
      end
   end

   // MAC pipeline: read operands, multiply, accumulate
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q    <= '0;
         h_q    <= '0;
         v1_q   <= 1'b0;
         prod_q <= '0;
         v2_q   <= 1'b0;
         acc    <= '0;
      end else begin
         v1_q <= (state == S_RUN);
         if (state == S_RUN) begin
            x_q <= mem[r_ptr];
            h_q <= coef_rom[tap_idx];
         end
         prod_q <= PW'(x_q) * PW'(h_q);
         v2_q   <= v1_q;
         if (start)     acc <= '0;
         else if (v2_q) acc <= acc + AW'(prod_q);
      end
   end

   // Round half up, arithmetic shift, then clamp to the output range
   always_comb begin
      rnd_sum = $signed({acc[AW-1], acc}) + RND;
      rnd_t   = rnd_sum >>> SHIFT;
      if (rnd_t > OMAX)      sat_val = OMAX[DW-1:0];
      else if (rnd_t < OMIN) sat_val = OMIN[DW-1:0];
      else                   sat_val = rnd_t[DW-1:0];
   end

   // Output register and sticky overrun flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filter_out <= '0;
         overrun    <= 1'b0;
      end else begin
         if (state_nxt == S_OUT)            filter_out <= sat_val;
         if (trigger && state != S_IDLE)    overrun    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cic_comp_down_mac.sv
// Directed testbench for cic_comp_down_mac. Three instances share the input
// stream: a ramp-coefficient filter with no shift, a single-tap Q1.18 filter
// for rounding, and a flat Q1.18 filter for saturation.
`timescale 1ns/1ps
module tb_cic_comp_down_mac;

   localparam int DW    = 16;
   localparam int CW    = 19;
   localparam int NTAPS = 120;
   localparam int DEPTH = 128;

   typedef logic [CW*NTAPS-1:0] coef_vec_t;

   function automatic coef_vec_t ramp_coeffs();
      coef_vec_t r = '0;
      for (int k = 0; k < NTAPS; k++) r[k*CW +: CW] = CW'(k + 1);
      return r;
   endfunction

   function automatic coef_vec_t flat_coeffs(input int n);
      coef_vec_t r = '0;
      for (int k = 0; k < n; k++) r[k*CW +: CW] = CW'(32'h0002_0000);
      return r;
   endfunction

   localparam coef_vec_t H_RAMP = ramp_coeffs();
   localparam coef_vec_t H_UNIT = flat_coeffs(1);
   localparam coef_vec_t H_FLAT = flat_coeffs(NTAPS);

   logic                 clk        = 1'b0;
   logic                 reset_n    = 1'b0;
   logic                 clk_enable = 1'b0;
   logic signed [DW-1:0] filter_in  = '0;

   logic signed [DW-1:0] fo_a, fo_b, fo_c;
   logic                 ce_a, ce_b, ce_c;
   logic                 busy_a, busy_b, busy_c;
   logic                 ovr_a, ovr_b, ovr_c;

   int errors = 0;
   int checks = 0;

   int                   ce_cnt_a = 0;
   int                   ce_cnt_b = 0;
   int                   ce_cnt_c = 0;
   logic signed [DW-1:0] last_a   = '0;
   logic signed [DW-1:0] last_b   = '0;
   logic signed [DW-1:0] last_c   = '0;

   cic_comp_down_mac #(
      .DW(DW), .CW(CW), .NTAPS(NTAPS), .DEPTH(DEPTH), .SHIFT(0),
      .COEFF_INIT_FILE(""), .COEFFS(H_RAMP)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .filter_in(filter_in),
      .filter_out(fo_a), .ce_out(ce_a), .busy(busy_a), .overrun(ovr_a)
   );

   cic_comp_down_mac #(
      .DW(DW), .CW(CW), .NTAPS(NTAPS), .DEPTH(DEPTH), .SHIFT(18),
      .COEFF_INIT_FILE(""), .COEFFS(H_UNIT)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .filter_in(filter_in),
      .filter_out(fo_b), .ce_out(ce_b), .busy(busy_b), .overrun(ovr_b)
   );

   cic_comp_down_mac #(
      .DW(DW), .CW(CW), .NTAPS(NTAPS), .DEPTH(DEPTH), .SHIFT(18),
      .COEFF_INIT_FILE(""), .COEFFS(H_FLAT)
   ) dut_c (
      .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .filter_in(filter_in),
      .filter_out(fo_c), .ce_out(ce_c), .busy(busy_c), .overrun(ovr_c)
   );

   always #5 clk = ~clk;

   // Record every output strobe and the value presented with it
   always @(negedge clk) begin
      if (ce_a === 1'b1) begin ce_cnt_a++; last_a = fo_a; end
      if (ce_b === 1'b1) begin ce_cnt_b++; last_b = fo_b; end
      if (ce_c === 1'b1) begin ce_cnt_c++; last_c = fo_c; end
   end

   // One input strobe, then idle so that strobes are gap clocks apart
   task automatic send(input logic signed [DW-1:0] x, input int gap);
      @(negedge clk);
      clk_enable = 1'b1;
      filter_in  = x;
      @(negedge clk);
      clk_enable = 1'b0;
      filter_in  = '0;
      repeat (gap - 2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      clk_enable = 1'b0;
      filter_in  = '0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({fo_a, ce_a, busy_a, ovr_a} !== 19'b0) begin
         errors++;
         $display("FAIL reset_a: got %h expected 0", {fo_a, ce_a, busy_a, ovr_a});
      end
      checks++;
      if ({fo_b, ce_b, busy_b, ovr_b} !== 19'b0) begin
         errors++;
         $display("FAIL reset_b: got %h expected 0", {fo_b, ce_b, busy_b, ovr_b});
      end
      checks++;
      if ({fo_c, ce_c, busy_c, ovr_c} !== 19'b0) begin
         errors++;
         $display("FAIL reset_c: got %h expected 0", {fo_c, ce_c, busy_c, ovr_c});
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_latency();
      int busy_cycles = 0;
      int first_busy  = -1;
      int last_busy   = -1;
      int ce_at       = -1;
      int ce_pulses   = 0;
      logic signed [DW-1:0] held = '0;
      do_reset();
      send(16'sd0, 10);
      @(negedge clk);
      clk_enable = 1'b1;
      filter_in  = 16'sd5;
      for (int i = 1; i <= 160; i++) begin
         @(negedge clk);
         clk_enable = 1'b0;
         filter_in  = '0;
         if (busy_a === 1'b1) begin
            busy_cycles++;
            if (first_busy < 0) first_busy = i;
            last_busy = i;
         end
         if (ce_a === 1'b1) begin
            ce_pulses++;
            ce_at = i;
            held  = fo_a;
         end
      end
      checks++;
      if (first_busy != 1) begin errors++; $display("FAIL busy_rise: got %0d expected 1", first_busy); end
      checks++;
      if (last_busy != 124) begin errors++; $display("FAIL busy_fall: got %0d expected 124", last_busy); end
      checks++;
      if (busy_cycles != 124) begin errors++; $display("FAIL busy_len: got %0d expected 124", busy_cycles); end
      checks++;
      if (ce_at != 124) begin errors++; $display("FAIL ce_latency: got %0d expected 124", ce_at); end
      checks++;
      if (ce_pulses != 1) begin errors++; $display("FAIL ce_width: got %0d expected 1", ce_pulses); end
      checks++;
      if (held !== 16'sd5) begin errors++; $display("FAIL ce_value: got %0d expected 5", held); end
      checks++;
      if (fo_a !== 16'sd5) begin errors++; $display("FAIL out_hold: got %0d expected 5", fo_a); end
   endtask

   task automatic test_impulse();
      int base;
      logic signed [DW-1:0] exp_v;
      do_reset();
      base = ce_cnt_a;
      for (int j = 1; j <= 61; j++) begin
         send(16'sd0, 100);
         send((j == 1) ? 16'sd1 : 16'sd0, 100);
         repeat (30) @(negedge clk);
         #1;
         exp_v = (j <= 60) ? DW'(2 * j - 1) : '0;
         checks++;
         if (last_a !== exp_v) begin
            errors++;
            $display("FAIL impulse_%0d: got %0d expected %0d", j, last_a, exp_v);
         end
      end
      checks++;
      if (ce_cnt_a - base != 61) begin
         errors++;
         $display("FAIL impulse_count: got %0d expected 61", ce_cnt_a - base);
      end
      checks++;
      if (ovr_a !== 1'b0) begin errors++; $display("FAIL impulse_overrun: got %b expected 0", ovr_a); end
   endtask

   task automatic test_rounding();
      logic signed [DW-1:0] rin  [6];
      logic signed [DW-1:0] rexp [6];
      rin  = '{16'sd3, -16'sd3, 16'sd1, -16'sd1, 16'sd32767, 16'sh8000};
      rexp = '{16'sd2, -16'sd1, 16'sd1, 16'sd0, 16'sd16384, -16'sd16384};
      for (int i = 0; i < 6; i++) begin
         send(16'sd0, 130);
         send(rin[i], 130);
         #1;
         checks++;
         if (last_b !== rexp[i]) begin
            errors++;
            $display("FAIL round_x%0d: got %0d expected %0d", rin[i], last_b, rexp[i]);
         end
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 130; i++) send(16'sd32767, 63);
      repeat (130) @(negedge clk);
      #1;
      checks++;
      if (last_c !== 16'sd32767) begin errors++; $display("FAIL sat_pos_q18: got %0d expected 32767", last_c); end
      checks++;
      if (last_a !== 16'sd32767) begin errors++; $display("FAIL sat_pos_q0: got %0d expected 32767", last_a); end
      for (int i = 0; i < 130; i++) send(16'sh8000, 63);
      repeat (130) @(negedge clk);
      #1;
      checks++;
      if (last_c !== 16'sh8000) begin errors++; $display("FAIL sat_neg_q18: got %0d expected -32768", last_c); end
      checks++;
      if (last_a !== 16'sh8000) begin errors++; $display("FAIL sat_neg_q0: got %0d expected -32768", last_a); end
      checks++;
      if (ovr_c !== 1'b0) begin errors++; $display("FAIL sat_overrun: got %b expected 0", ovr_c); end
   endtask

   task automatic test_reset_mid_run();
      int base;
      send(16'sd0, 10);
      @(negedge clk);
      clk_enable = 1'b1;
      filter_in  = 16'sd4;
      @(negedge clk);
      clk_enable = 1'b0;
      filter_in  = '0;
      repeat (59) @(negedge clk);
      #1;
      checks++;
      if (busy_a !== 1'b1) begin errors++; $display("FAIL midrun_busy: got %b expected 1", busy_a); end
      base = ce_cnt_a;
      reset_n = 1'b0;
      #1;
      checks++;
      if (fo_a !== 16'sd0) begin errors++; $display("FAIL midrun_out_a: got %0d expected 0", fo_a); end
      checks++;
      if (fo_c !== 16'sd0) begin errors++; $display("FAIL midrun_out_c: got %0d expected 0", fo_c); end
      checks++;
      if ({busy_a, ce_a, ovr_a} !== 3'b000) begin
         errors++;
         $display("FAIL midrun_flags: got %b expected 000", {busy_a, ce_a, ovr_a});
      end
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (150) @(negedge clk);
      #1;
      checks++;
      if (ce_cnt_a != base) begin
         errors++;
         $display("FAIL midrun_no_ce: got %0d expected 0", ce_cnt_a - base);
      end
      for (int j = 1; j <= 4; j++) begin
         send(16'sd0, 100);
         send((j == 1) ? 16'sd1 : 16'sd0, 100);
         repeat (30) @(negedge clk);
         #1;
         checks++;
         if (last_a !== DW'(2 * j - 1)) begin
            errors++;
            $display("FAIL post_reset_impulse_%0d: got %0d expected %0d", j, last_a, 2 * j - 1);
         end
      end
   endtask

   task automatic test_overrun();
      int base;
      do_reset();
      base = ce_cnt_a;
      send(16'sd0, 50);
      send(16'sd7, 50);
      send(16'sd0, 50);
      #1;
      checks++;
      if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_before: got %b expected 0", ovr_a); end
      send(16'sd9, 50);
      #1;
      checks++;
      if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", ovr_a); end
      checks++;
      if (last_a !== 16'sd7) begin errors++; $display("FAIL ovr_inflight: got %0d expected 7", last_a); end
      checks++;
      if (ce_cnt_a - base != 1) begin errors++; $display("FAIL ovr_count: got %0d expected 1", ce_cnt_a - base); end
      send(16'sd0, 50);
      send(16'sd0, 50);
      repeat (80) @(negedge clk);
      #1;
      checks++;
      if (last_a !== 16'sd62) begin errors++; $display("FAIL ovr_next: got %0d expected 62", last_a); end
      checks++;
      if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", ovr_a); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_impulse();
      test_rounding();
      test_saturation();
      test_reset_mid_run();
      test_overrun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
